dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Controller sitting between the RV32I load/store path and the word-wide `Data_Memory`. It arbitrates between the core's load/store unit and a debug/loader port and performs byte/halfword formatting: sign/zero extension on loads, read-modify-write on sub-word stores. Misaligned and out-of-range accesses are rejected with an error response instead of touching memory.

## Interface
Parameters:
- `DEPTH_LOG2`, default 8: number of word-index bits implemented by `Data_Memory`. Word indices ≥ 2^DEPTH_LOG2 are out of range.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core request. Held, with all `c_*` fields stable, until `c_gnt`.
- `c_we`  in  1  1 = store, 0 = load.
- `c_addr`  in  32  byte address.
- `c_wdata`  in  32  store data. Lane 0 carries SB/SH data.
- `c_size`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and yields an error response.
- `c_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `c_gnt`  out  1  request accepted this cycle.
- `c_rvalid`  out  1  one-cycle completion pulse, for loads and stores.
- `c_rdata`  out  32  load result; valid with `c_rvalid`, otherwise 0.
- `c_err`  out  1  error flag; valid with `c_rvalid`.
- `d_req`, `d_we`, `d_addr[31:0]`, `d_wdata[31:0]`  in  debug request. Word-only accesses, same hold rule as the core port.
- `d_gnt`, `d_rvalid`, `d_rdata[31:0]`, `d_err`  out  debug response, same semantics as the core port.
- `mem_addr`  out  32  word index: zero-extended `addr[31:2]`.
- `mem_data`  out  32  write data to memory.
- `mem_we`  out  1  memory write enable.
- `mem_q`  in  32  memory read data. Sampled one cycle after `mem_addr` is driven.

## Operation
- **States:**
  - IDLE → on acceptance: ERR if the request is bad, READ for loads, WRITE for word stores, RMW_RD for sub-word stores.
  - READ → RESP.
  - RMW_RD → WRITE.
  - WRITE → RESP.
  - ERR → RESP.
  - RESP → IDLE.
- **Grant:** `*_gnt` is combinational and only asserted in IDLE. The request fields, the requester ID and the access kind are latched on the granting edge.
- **Arbitration:** round-robin with a last-granted pointer; reset value = debug, so the core wins the first tie. When both requests are pending, the port not granted last wins. A lone requester is always granted.
- **Bad request:** `addr` misaligned for its size (half with `addr[0]=1`; word with `addr[1:0]≠0`), `size=3`, or word index out of range. The path is IDLE→ERR→RESP with `err=1` and `rdata=0`. `mem_we` never asserts.
- **Load extraction:** little-endian, lane selected by `addr[1:0]` (byte) or `addr[1]` (half). Sign-extend unless `c_unsigned`.
- **Sub-word store:**
  - RMW_RD drives `mem_addr`.
  - WRITE drives `mem_data` = sampled `mem_q` with the selected lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`, and `mem_we=1`.
- **Drive rules:** `mem_we` is 1 only in WRITE. `mem_addr` holds the latched word index in READ, RMW_RD and WRITE, and is 0 otherwise.
- **Response:** in RESP, only the latched requester's `rvalid` pulses; `err`/`rdata` are routed to that port and held 0 on the other.

## Timing
- **Reset:** all outputs 0, state IDLE, pointer = debug. Asserting `rst` mid-transaction aborts it immediately. `mem_we` drops asynchronously, and no response is ever produced for the aborted request.
- **Latency, measured from the grant cycle G:**
  - Load: `rvalid` at G+2.
  - Word store: write at G+1, `rvalid` at G+2.
  - Sub-word store: read at G+1, write at G+2, `rvalid` at G+3.
  - Error: `rvalid` at G+2.
- **Throughput:** the next grant comes no earlier than the cycle after RESP (back in IDLE).
- **Deasserted request:** a request deasserted before grant is silently dropped.

## Configuration
- **`DMEM_ARB_DEBUG_PORT_EN` defined:** debug port arbitrated as above.
- **Undefined:**
  - `d_gnt`, `d_rvalid`, `d_rdata` and `d_err` are tied to 0 and `d_*` inputs are ignored.
  - The core is always granted; no pointer logic.
  - Port list is identical in both builds.

## Structure
- **Package `dmem_pkg`:**
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`.
  - State enum.
  - Requester ID constants `REQ_CORE`, `REQ_DBG`.
- **Sub-module `dmem_lane_fmt`:** combinational load extract/extend and store lane merge. Inputs: `addr[1:0]`, size, unsigned, `mem_q`, `wdata`. Outputs: `rdata`, `merged`.
- **Top level:** FSM, arbiter, latches.

## Test plan
- **Reset:** `rst=0` for 2 cycles → all outputs 0. Release, then core LW at 0x134 → `mem_addr=77` at G+1, `c_rvalid` at G+2 returning memory content.
- **Word store then load:** core SW `0x0000002D` to 0x134, then LW 0x134 → `mem_we=1` at G+1 with `mem_data=0x2D`, and the load returns `0x0000002D`.
- **Sub-word formatting:** word 0x134 = `0x11223344`.
  - SB `0xFF` to 0x136 → written word `0x11FF3344`, ack at G+3.
  - LB 0x136 → `0xFFFFFFFF`.
  - LBU → `0x000000FF`.
  - LH 0x136 → `0x000011FF`.
- **Errors, no memory access in either case:**
  - LW at 0x135 → `c_err=1`, `c_rdata=0`, `mem_we` never 1.
  - With `DEPTH_LOG2=8`, LW at 0x400 → `c_err=1`.
- **Contention:** `c_req` and `d_req` held together for 3 transactions → grant order core, debug, core. Each `rvalid` appears only on the owning port.
- **Reset mid-RMW:** SB issued, `rst` asserted at G+1 → `mem_we` stays 0, no `rvalid`, memory word unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, requester IDs,
// FSM states and the alignment rule used when a request is accepted.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_ERR    = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Size code 3 is illegal and counts as misaligned so it takes the error path.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte/halfword formatting: little-endian load extraction with
// sign/zero extension, and lane merge of store data into a read-back word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_mem_q,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_mem_q[7:0];
      2'd1:    w_byte = i_mem_q[15:8];
      2'd2:    w_byte = i_mem_q[23:16];
      default: w_byte = i_mem_q[31:24];
    endcase
    w_half = i_addr[1] ? i_mem_q[31:16] : i_mem_q[15:0];
  end

  always_comb begin
    case (i_size)
      SZ_B:    o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_W:    o_rdata = i_mem_q;
      default: o_rdata = 32'd0;
    endcase
  end

  always_comb begin
    o_merged = i_mem_q;
    case (i_size)
      SZ_B: begin
        case (i_addr)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_addr[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      SZ_W:    o_merged = i_wdata;
      default: o_merged = i_mem_q;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Load/store controller in front of a synchronous-read word memory, arbitrating
// core and debug ports. Debug port present only with DMEM_ARB_DEBUG_PORT_EN defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants are issued only here
// ST_READ   | word index on mem_addr for a load
// ST_RMW_RD | word index on mem_addr to fetch the word a sub-word store patches
// ST_WRITE  | mem_we high, merged or full word on mem_data
// ST_ERR    | rejected request; memory untouched
// ST_RESP   | one-cycle rvalid to the latched requester
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [1:0]  c_size,
  input  logic        c_unsigned,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic [31:0] mem_q
);

  state_t      r_state;
  logic        r_id;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;

  logic        w_idle;
  logic        w_any_req;
  logic        w_pick_dbg;
  logic        w_accept;
  logic        w_bad;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [1:0]  w_sel_size;
  logic        w_sel_uns;
  logic [31:0] w_fmt_rdata;
  logic [31:0] w_merged;
  logic        w_resp;

  assign w_idle = (r_state == ST_IDLE);

`ifdef DMEM_ARB_DEBUG_PORT_EN
  logic r_last;

  // Round-robin: on a tie the port that did not win last time goes first.
  assign w_pick_dbg = d_req & (~c_req | (r_last == REQ_CORE));
  assign w_any_req  = c_req | d_req;

  always_comb begin
    if (w_pick_dbg) begin
      w_sel_we    = d_we;
      w_sel_addr  = d_addr;
      w_sel_wdata = d_wdata;
      w_sel_size  = SZ_W;
      w_sel_uns   = 1'b0;
    end else begin
      w_sel_we    = c_we;
      w_sel_addr  = c_addr;
      w_sel_wdata = c_wdata;
      w_sel_size  = c_size;
      w_sel_uns   = c_unsigned;
    end
  end
`else
  logic w_unused_dbg;

  assign w_unused_dbg = ^{d_req, d_we, d_addr, d_wdata};
  assign w_pick_dbg   = 1'b0;
  assign w_any_req    = c_req;
  assign w_sel_we     = c_we;
  assign w_sel_addr   = c_addr;
  assign w_sel_wdata  = c_wdata;
  assign w_sel_size   = c_size;
  assign w_sel_uns    = c_unsigned;
`endif

  assign w_accept = w_idle & w_any_req;
  assign w_bad    = is_misaligned(w_sel_addr[1:0], w_sel_size) |
                    ((w_sel_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_id    <= REQ_CORE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
`ifdef DMEM_ARB_DEBUG_PORT_EN
      r_last  <= REQ_DBG;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_pick_dbg ? REQ_DBG : REQ_CORE;
            r_we    <= w_sel_we;
            r_err   <= w_bad;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_size  <= w_sel_size;
            r_uns   <= w_sel_uns;
`ifdef DMEM_ARB_DEBUG_PORT_EN
            r_last  <= w_pick_dbg ? REQ_DBG : REQ_CORE;
`endif
            if (w_bad)                   r_state <= ST_ERR;
            else if (!w_sel_we)          r_state <= ST_READ;
            else if (w_sel_size == SZ_W) r_state <= ST_WRITE;
            else                         r_state <= ST_RMW_RD;
          end
        end
        ST_READ:   r_state <= ST_RESP;
        ST_RMW_RD: r_state <= ST_WRITE;
        ST_WRITE:  r_state <= ST_RESP;
        ST_ERR:    r_state <= ST_RESP;
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // mem_q arrives one cycle after the address, so RESP and WRITE see the word
  // fetched in READ and RMW_RD respectively.
  dmem_lane_fmt u_lane_fmt (
    .i_addr     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_mem_q    (mem_q),
    .i_wdata    (r_wdata),
    .o_rdata    (w_fmt_rdata),
    .o_merged   (w_merged)
  );

  assign w_resp   = (r_state == ST_RESP);
  assign mem_we   = (r_state == ST_WRITE);
  assign mem_data = mem_we ? w_merged : 32'd0;
  assign mem_addr = (r_state == ST_READ || r_state == ST_RMW_RD || r_state == ST_WRITE) ?
                    {2'b00, r_addr[31:2]} : 32'd0;

  assign c_gnt    = w_idle & c_req & ~w_pick_dbg;
  assign c_rvalid = w_resp & (r_id == REQ_CORE);
  assign c_err    = c_rvalid & r_err;
  assign c_rdata  = (c_rvalid & ~r_err & ~r_we) ? w_fmt_rdata : 32'd0;

`ifdef DMEM_ARB_DEBUG_PORT_EN
  assign d_gnt    = w_idle & w_pick_dbg;
  assign d_rvalid = w_resp & (r_id == REQ_DBG);
  assign d_err    = d_rvalid & r_err;
  assign d_rdata  = (d_rvalid & ~r_err & ~r_we) ? w_fmt_rdata : 32'd0;
`else
  assign d_gnt    = 1'b0;
  assign d_rvalid = 1'b0;
  assign d_err    = 1'b0;
  assign d_rdata  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, randomized traffic against an
// arithmetic memory model, reset-abort and port-contention sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, c_uns = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [1:0]  c_size = '0;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_data, mem_q;
  logic        mem_we;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_size(c_size), .c_unsigned(c_uns),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Synchronous-read word memory standing in for Data_Memory.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_data;
    mem_q <= mem[mem_addr[7:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_we_at;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mkv(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size,
                               logic uns, logic [31:0] rd, logic er, int lat, int we_at, logic [31:0] wd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat; v.exp_we_at = we_at; v.exp_wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: expected response from the access rules, applied to ref_mem.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int we_at, output logic [31:0] wd);
    int idx, sh, width;
    logic [31:0] w, mask, v;
    er = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
         (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 256);
    rd = 0; wd = 0; we_at = 0; lat = 2;
    if (er) return;
    idx   = int'(addr / 4);
    sh    = int'(addr % 4) * 8;
    width = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    w     = ref_mem[idx];
    if (!we) begin
      v = (w >> sh) & mask;
      if (!uns && width < 32 && v[width-1]) v = v | ~mask;
      rd = v;
    end else begin
      wd = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[idx] = wd;
      lat   = (width == 32) ? 2 : 3;
      we_at = lat - 1;
    end
  endtask

  task automatic core_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic ok, output logic [31:0] rd, output logic er, output int lat,
                          output int we_at, output logic [31:0] wd, output logic [31:0] a1,
                          output int stray);
    int n;
    c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_size = size; c_uns = uns;
    ok = 1'b0; rd = 0; er = 0; lat = 0; we_at = 0; wd = 0; a1 = 0; stray = 0;
    n = 0;
    #1;
    while (!c_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!c_gnt) begin
      c_req = 1'b0;
      return;
    end
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin a1 = mem_addr; c_req = 1'b0; end
      if (mem_we && we_at == 0) begin we_at = k; wd = mem_data; end
      if (d_rvalid) stray++;
      if (c_rvalid) begin lat = k; rd = c_rdata; er = c_err; break; end
    end
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input int exp_we_at, input logic [31:0] exp_wd);
    logic ok, er;
    logic [31:0] rd, wd, a1;
    int lat, we_at, stray;
    core_txn(we, addr, wdata, size, uns, ok, rd, er, lat, we_at, wd, a1, stray);
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL %s.grant: no c_gnt within 20 cycles, required grant", tag);
      return;
    end
    chk($sformatf("%s.lat", tag), lat, exp_lat);
    chk($sformatf("%s.err", tag), er, exp_err);
    chk($sformatf("%s.rdata", tag), rd, exp_rd);
    chk($sformatf("%s.we_at", tag), we_at, exp_we_at);
    if (exp_we_at != 0) chk($sformatf("%s.wdata", tag), wd, exp_wd);
    chk($sformatf("%s.mem_addr", tag), a1, exp_err ? 32'd0 : (addr >> 2));
    chk($sformatf("%s.d_rvalid", tag), stray, 0);
  endtask

  vec_t vecs [16];

  initial begin
    logic [31:0] m_rd, m_wd, addr, v;
    logic m_er, we, uns, seen, ok_g;
    logic [1:0] size;
    int m_lat, m_we_at, n;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[77] = 32'hCAFE_BABE;
    ref_mem[77] = 32'hCAFE_BABE;

    vecs[0]  = mkv(1'b0, 32'h134, 32'h0,         2'd2, 1'b0, 32'hCAFE_BABE, 1'b0, 2, 0, 32'h0);
    vecs[1]  = mkv(1'b1, 32'h134, 32'h0000_002D, 2'd2, 1'b0, 32'h0,         1'b0, 2, 1, 32'h0000_002D);
    vecs[2]  = mkv(1'b0, 32'h134, 32'h0,         2'd2, 1'b0, 32'h0000_002D, 1'b0, 2, 0, 32'h0);
    vecs[3]  = mkv(1'b1, 32'h134, 32'h1122_3344, 2'd2, 1'b0, 32'h0,         1'b0, 2, 1, 32'h1122_3344);
    vecs[4]  = mkv(1'b1, 32'h136, 32'hABCD_EFFF, 2'd0, 1'b0, 32'h0,         1'b0, 3, 2, 32'h11FF_3344);
    vecs[5]  = mkv(1'b0, 32'h136, 32'h0,         2'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0);
    vecs[6]  = mkv(1'b0, 32'h136, 32'h0,         2'd0, 1'b1, 32'h0000_00FF, 1'b0, 2, 0, 32'h0);
    vecs[7]  = mkv(1'b0, 32'h136, 32'h0,         2'd1, 1'b0, 32'h0000_11FF, 1'b0, 2, 0, 32'h0);
    vecs[8]  = mkv(1'b0, 32'h134, 32'h0,         2'd1, 1'b1, 32'h0000_3344, 1'b0, 2, 0, 32'h0);
    vecs[9]  = mkv(1'b0, 32'h137, 32'h0,         2'd0, 1'b0, 32'h0000_0011, 1'b0, 2, 0, 32'h0);
    vecs[10] = mkv(1'b1, 32'h134, 32'h1234_BEEF, 2'd1, 1'b0, 32'h0,         1'b0, 3, 2, 32'h11FF_BEEF);
    vecs[11] = mkv(1'b0, 32'h134, 32'h0,         2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0, 2, 0, 32'h0);
    vecs[12] = mkv(1'b0, 32'h135, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1, 2, 0, 32'h0);
    vecs[13] = mkv(1'b0, 32'h400, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1, 2, 0, 32'h0);
    vecs[14] = mkv(1'b1, 32'h137, 32'h0000_5555, 2'd1, 1'b0, 32'h0,         1'b1, 2, 0, 32'h0);
    vecs[15] = mkv(1'b0, 32'h134, 32'h0,         2'd3, 1'b0, 32'h0,         1'b1, 2, 0, 32'h0);

    // Reset held for two cycles: every output idle.
    repeat (2) @(negedge clk);
    #1;
    chk("reset.outputs", {31'd0, c_gnt | c_rvalid | c_err | d_gnt | d_rvalid | d_err | mem_we},
        32'd0);
    chk("reset.c_rdata", c_rdata, 32'd0);
    chk("reset.d_rdata", d_rdata, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
            m_rd, m_er, m_lat, m_we_at, m_wd);
      run_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
              vecs[i].uns, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat,
              vecs[i].exp_we_at, vecs[i].exp_wd);
    end

    for (int i = 0; i < 150; i++) begin
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      v   = $urandom;
      model(we, addr, v, size, uns, m_rd, m_er, m_lat, m_we_at, m_wd);
      run_chk($sformatf("rnd%0d", i), we, addr, v, size, uns, m_rd, m_er, m_lat, m_we_at, m_wd);
    end

    // Reset during RMW_RD: nothing written, no response.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h134; c_wdata = 32'hAA; c_size = 2'd0; c_uns = 1'b0;
    n = 0; #1;
    while (!c_gnt && n < 20) begin @(negedge clk); #1; n++; end
    ok_g = c_gnt;
    chk("rmw_rst.grant", {31'd0, ok_g}, 32'd1);
    @(negedge clk);
    c_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmw_rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rmw_rst.mem_addr", mem_addr, 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_we || c_rvalid || d_rvalid) seen = 1'b1;
    end
    chk("rmw_rst.quiet", {31'd0, seen}, 32'd0);
    rst = 1'b1;

    // Reset while WRITE is driving: mem_we must fall without a clock.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h134; c_wdata = 32'h5555_AAAA; c_size = 2'd2;
    n = 0; #1;
    while (!c_gnt && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    chk("wr_rst.we_before", {31'd0, mem_we}, 32'd1);
    c_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("wr_rst.we_after", {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifdef DMEM_ARB_DEBUG_PORT_EN
    begin
      int ng, nr;
      logic owner, drop;
      logic [2:0] gorder;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h134; c_size = 2'd2; c_uns = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
      ng = 0; nr = 0; owner = 1'b0; drop = 1'b0; gorder = 3'b111;
      for (int cyc = 0; cyc < 60 && nr < 3; cyc++) begin
        @(negedge clk);
        if (drop) begin c_req = 1'b0; d_req = 1'b0; drop = 1'b0; end
        #1;
        if (c_rvalid || d_rvalid) begin
          chk($sformatf("cont.owner%0d", nr), {30'd0, c_rvalid, d_rvalid}, owner ? 32'd1 : 32'd2);
          if (owner) chk($sformatf("cont.d_rdata%0d", nr), d_rdata, ref_mem[128]);
          else       chk($sformatf("cont.c_rdata%0d", nr), c_rdata, ref_mem[77]);
          nr++;
        end
        if (c_gnt || d_gnt) begin
          if (ng < 3) gorder[ng] = d_gnt;
          owner = d_gnt;
          ng++;
          if (ng == 3) drop = 1'b1;
        end
      end
      chk("cont.grants", ng, 3);
      chk("cont.order", {29'd0, gorder}, 32'b010);
      chk("cont.responses", nr, 3);
      c_req = 1'b0; d_req = 1'b0;
    end
`else
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h134; d_wdata = 32'hDEAD_BEEF;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (d_gnt || c_gnt || mem_we || d_rvalid || mem_addr != 32'd0) seen = 1'b1;
    end
    chk("nodbg.ignored", {31'd0, seen}, 32'd0);
    model(1'b0, 32'h134, 32'h0, 2'd2, 1'b0, m_rd, m_er, m_lat, m_we_at, m_wd);
    run_chk("nodbg.lw", 1'b0, 32'h134, 32'h0, 2'd2, 1'b0, m_rd, m_er, m_lat, m_we_at, m_wd);
    d_req = 1'b0;
`endif

    // Word touched by both aborted stores must still hold its old value.
    model(1'b0, 32'h134, 32'h0, 2'd2, 1'b0, m_rd, m_er, m_lat, m_we_at, m_wd);
    run_chk("post_rst.lw", 1'b0, 32'h134, 32'h0, 2'd2, 1'b0, m_rd, m_er, m_lat, m_we_at, m_wd);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
